// File: rtl/pio_pulse_sequencer.sv
// Pulse-train sequencer commanded by an HPS toggle/opcode PIO word; reports {ack,busy,err,armed,done_cnt}.
// Latency: ack 3 edges after a toggle change (SYNC_STAGES=2); pulse_out rises the cycle after FIRE/trigger.
// Backpressure: none; one command per toggle, and commands that cannot run now are dropped and flagged in err.
module pio_pulse_sequencer #(
  parameter int PW_SCALE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] pio_out,
  output logic [7:0] pio_in,
  input  logic       trig_in,
  output logic       pulse_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    PULSE_HI = 2'd2,
    PULSE_LO = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WIDTH = 3'd1;
  localparam logic [2:0] OP_COUNT = 3'd2;
  localparam logic [2:0] OP_ARM   = 3'd3;
  localparam logic [2:0] OP_FIRE  = 3'd4;
  localparam logic [2:0] OP_ABORT = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  // 12 bits covers the worst case (15+1)*255-1 = 4079 without wrapping.
  localparam logic [11:0] PW_SCALE_W = 12'(PW_SCALE);

  // Synchronisers and trigger edge detection
  logic [SYNC_STAGES-1:0] tog_sync;
  logic [SYNC_STAGES-1:0] trig_sync;
  logic                   trig_prev;
  logic                   trig_edge;

  // Architectural state
  state_t      state, state_nxt;
  logic        ack;
  logic        err, err_nxt;
  logic [3:0]  done_cnt, done_nxt;
  logic [3:0]  width_reg, width_nxt;
  logic [3:0]  count_reg, count_nxt;
  logic [11:0] wcnt, wcnt_nxt;
  logic [3:0]  pcnt, pcnt_nxt;

  // Command decode
  logic        cmd_vld;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_arg;
  logic        busy;
  logic        armed;
  logic [11:0] width_load;

  assign cmd_vld = tog_sync[SYNC_STAGES-1] ^ ack;
  assign cmd_op  = pio_out[6:4];
  assign cmd_arg = pio_out[3:0];
  assign busy    = (state != IDLE);
  assign armed   = (state == ARMED);

  // Phase length minus one, so a phase lasts exactly (WIDTH+1)*PW_SCALE clocks.
  assign width_load = ({8'd0, width_reg} + 12'd1) * PW_SCALE_W - 12'd1;

  assign pio_in = {ack, busy, err, armed, done_cnt};

  // Toggle and trigger synchronisers plus a registered trigger rising-edge strobe.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tog_sync  <= '0;
      trig_sync <= '0;
      trig_prev <= 1'b0;
      trig_edge <= 1'b0;
    end else begin
      tog_sync  <= {tog_sync[SYNC_STAGES-2:0], pio_out[7]};
      trig_sync <= {trig_sync[SYNC_STAGES-2:0], trig_in};
      trig_prev <= trig_sync[SYNC_STAGES-1];
      trig_edge <= trig_sync[SYNC_STAGES-1] & ~trig_prev;
    end
  end

  // State, counters, configuration and status registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      ack       <= 1'b0;
      err       <= 1'b0;
      done_cnt  <= 4'd0;
      width_reg <= 4'd0;
      count_reg <= 4'd0;
      wcnt      <= 12'd0;
      pcnt      <= 4'd0;
      pulse_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      err       <= err_nxt;
      done_cnt  <= done_nxt;
      width_reg <= width_nxt;
      count_reg <= count_nxt;
      wcnt      <= wcnt_nxt;
      pcnt      <= pcnt_nxt;
      pulse_out <= (state_nxt == PULSE_HI);
      if (cmd_vld) begin
        ack <= ~ack;
      end
    end
  end

  // Sequencing first, then an accepted command overrides it for this cycle.
  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    done_nxt  = done_cnt;
    width_nxt = width_reg;
    count_nxt = count_reg;
    wcnt_nxt  = wcnt;
    pcnt_nxt  = pcnt;

    case (state)
      IDLE: begin
        wcnt_nxt = wcnt;
      end
      ARMED: begin
        if (trig_edge) begin
          state_nxt = PULSE_HI;
          wcnt_nxt  = width_load;
          pcnt_nxt  = count_reg;
        end
      end
      PULSE_HI: begin
        if (wcnt == 12'd0) begin
          state_nxt = PULSE_LO;
          wcnt_nxt  = width_load;
        end else begin
          wcnt_nxt = wcnt - 12'd1;
        end
      end
      PULSE_LO: begin
        if (wcnt == 12'd0) begin
          if (pcnt == 4'd0) begin
            // Burst finished: done_cnt wraps 15 -> 0 naturally.
            state_nxt = IDLE;
            done_nxt  = done_cnt + 4'd1;
          end else begin
            state_nxt = PULSE_HI;
            wcnt_nxt  = width_load;
            pcnt_nxt  = pcnt - 4'd1;
          end
        end else begin
          wcnt_nxt = wcnt - 12'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (cmd_vld) begin
      case (cmd_op)
        OP_NOP: begin
          err_nxt = err;
        end
        OP_WIDTH: begin
          if (busy) err_nxt   = 1'b1;
          else      width_nxt = cmd_arg;
        end
        OP_COUNT: begin
          if (busy) err_nxt   = 1'b1;
          else      count_nxt = cmd_arg;
        end
        OP_ARM: begin
          if (busy) err_nxt   = 1'b1;
          else      state_nxt = ARMED;
        end
        OP_FIRE: begin
          if (busy) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = PULSE_HI;
            wcnt_nxt  = width_load;
            pcnt_nxt  = count_reg;
          end
        end
        OP_ABORT: begin
          // An abort that coincides with the last low phase must not count as completed.
          state_nxt = IDLE;
          wcnt_nxt  = 12'd0;
          pcnt_nxt  = 4'd0;
          done_nxt  = done_cnt;
        end
        OP_CLEAR: begin
          if (busy) begin
            err_nxt = 1'b1;
          end else begin
            err_nxt  = 1'b0;
            done_nxt = 4'd0;
          end
        end
        OP_RSVD: begin
          err_nxt = 1'b1;
        end
        default: begin
          err_nxt = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_pulse_sequencer.sv
// Bench for pio_pulse_sequencer: command driver, pulse-length scoreboard, directed status checks.
// Expected pulse phase lengths are queued when FIRE/trigger is driven and popped by the pulse monitor.
// All comparisons go through chk(); one TB_RESULT summary line at the end.
module tb_pio_pulse_sequencer;

  localparam int PW    = 4;
  localparam int SYNCS = 2;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WIDTH = 3'd1;
  localparam logic [2:0] OP_COUNT = 3'd2;
  localparam logic [2:0] OP_ARM   = 3'd3;
  localparam logic [2:0] OP_FIRE  = 3'd4;
  localparam logic [2:0] OP_ABORT = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic       clk_clk;
  logic       reset_reset_n;
  logic [7:0] pio_out;
  logic [7:0] pio_in;
  logic       trig_in;
  logic       pulse_out;

  int checks   = 0;
  int failures = 0;

  int exp_q[$];
  logic tog;
  logic mon_en;
  int exp_done;

  int hi_run;
  int lo_run;
  bit in_lo;

  pio_pulse_sequencer #(
    .PW_SCALE    (PW),
    .SYNC_STAGES (SYNCS)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .pio_out       (pio_out),
    .pio_in        (pio_in),
    .trig_in       (trig_in),
    .pulse_out     (pulse_out)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic pop_chk(input string tag, input int len);
    if (exp_q.size() == 0) chk({tag, "_unexpected"}, len, 0);
    else                   chk(tag, len, exp_q.pop_front());
  endtask

  task automatic push_burst(input int w, input int c);
    for (int i = 0; i <= c; i++) begin
      exp_q.push_back((w + 1) * PW);
      exp_q.push_back((w + 1) * PW);
    end
  endtask

  // Send one command and wait (bounded) for the ack bit to follow the toggle.
  task automatic send_cmd(input logic [2:0] op, input logic [3:0] arg);
    int lat;
    @(negedge clk_clk);
    tog     = ~tog;
    pio_out = {tog, op, arg};
    lat = 0;
    do begin
      @(posedge clk_clk);
      #1;
      lat++;
    end while (pio_in[7] !== tog && lat < 20);
    chk("ack_latency", lat, 3);
  endtask

  // Wait (bounded) until busy drops; returns cycles spent.
  task automatic wait_idle(output int n);
    n = 0;
    while (pio_in[6] === 1'b1 && n < 5000) begin
      @(posedge clk_clk);
      #1;
      n++;
    end
    chk("idle_reached", pio_in[6], 0);
  endtask

  // Pulse monitor: measures each high phase and the low phase that follows while busy.
  always @(negedge clk_clk) begin
    if (!mon_en) begin
      hi_run = 0;
      lo_run = 0;
      in_lo  = 0;
    end else begin
      if (pulse_out === 1'b1) begin
        if (in_lo) begin
          pop_chk("lo_len", lo_run);
          in_lo = 0;
        end
        hi_run++;
      end else begin
        if (hi_run != 0) begin
          pop_chk("hi_len", hi_run);
          hi_run = 0;
          in_lo  = 1;
          lo_run = 0;
        end
        if (in_lo) begin
          if (pio_in[6] === 1'b1) lo_run++;
          else begin
            pop_chk("lo_len", lo_run);
            in_lo = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi_seen;
    reset_reset_n = 1'b0;
    pio_out       = 8'h00;
    trig_in       = 1'b0;
    tog           = 1'b0;
    mon_en        = 1'b0;
    exp_done      = 0;

    // Reset state
    #23;
    chk("rst_pulse_out", pulse_out, 0);
    chk("rst_pio_in", pio_in, 8'h00);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;
    chk("post_rst_pio_in", pio_in, 8'h00);
    mon_en = 1'b1;

    // Single pulse: WIDTH=0 -> 4 high, 4 low
    send_cmd(OP_WIDTH, 4'd0);
    push_burst(0, 0);
    send_cmd(OP_FIRE, 4'd0);
    chk("fire_pulse_next", pulse_out, 1);
    chk("fire_busy", pio_in[6], 1);
    wait_idle(n);
    chk("single_len", n, 8);
    exp_done = (exp_done + 1) % 16;
    chk("single_done", pio_in[3:0], exp_done);

    // Burst: WIDTH=2, COUNT=3 -> 4 x (12 hi, 12 lo) = 96 clocks
    send_cmd(OP_WIDTH, 4'd2);
    send_cmd(OP_COUNT, 4'd3);
    push_burst(2, 3);
    send_cmd(OP_FIRE, 4'd0);
    wait_idle(n);
    chk("burst_len", n, 96);
    exp_done = (exp_done + 1) % 16;
    chk("burst_done", pio_in[3:0], exp_done);
    chk("burst_err", pio_in[5], 0);

    // Busy error: COUNT=5 during burst is dropped, err set, burst still 4 pulses
    push_burst(2, 3);
    send_cmd(OP_FIRE, 4'd0);
    send_cmd(OP_COUNT, 4'd5);
    chk("busy_err_set", pio_in[5], 1);
    chk("busy_still", pio_in[6], 1);
    wait_idle(n);
    exp_done = (exp_done + 1) % 16;
    chk("err_sticky", pio_in[5], 1);
    chk("err_burst_done", pio_in[3:0], exp_done);
    send_cmd(OP_CLEAR, 4'd0);
    exp_done = 0;
    chk("clear_ack_only", pio_in, {tog, 7'h00});

    // Reserved opcode sets err only
    send_cmd(OP_RSVD, 4'd9);
    chk("rsvd_status", pio_in, {tog, 1'b0, 1'b1, 1'b0, 4'd0});
    send_cmd(OP_NOP, 4'd0);
    chk("nop_keeps_err", pio_in[5], 1);
    send_cmd(OP_CLEAR, 4'd0);
    chk("rsvd_cleared", pio_in[5], 0);

    // Trigger in IDLE is ignored
    send_cmd(OP_WIDTH, 4'd0);
    send_cmd(OP_COUNT, 4'd0);
    @(negedge clk_clk);
    trig_in = 1'b1;
    hi_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_clk);
      #1;
      if (pulse_out === 1'b1) hi_seen++;
      if (i == 3) trig_in = 1'b0;
    end
    chk("idle_trig_nopulse", hi_seen, 0);
    chk("idle_trig_busy", pio_in[6], 0);

    // Armed trigger: pulse_out rises SYNC_STAGES+2 edges after trig_in
    send_cmd(OP_ARM, 4'd0);
    chk("armed_bit", pio_in[4], 1);
    chk("armed_busy", pio_in[6], 1);
    push_burst(0, 0);
    @(negedge clk_clk);
    trig_in = 1'b1;
    n = 0;
    do begin
      @(posedge clk_clk);
      #1;
      n++;
    end while (pulse_out !== 1'b1 && n < 20);
    chk("trig_latency", n, SYNCS + 2);
    chk("armed_bit_clr", pio_in[4], 0);
    trig_in = 1'b0;
    wait_idle(n);
    exp_done = (exp_done + 1) % 16;
    chk("trig_done", pio_in[3:0], exp_done);

    // Abort mid-PULSE_HI
    send_cmd(OP_WIDTH, 4'd3);
    mon_en = 1'b0;
    send_cmd(OP_FIRE, 4'd0);
    repeat (2) @(posedge clk_clk);
    #1;
    chk("abort_pre_hi", pulse_out, 1);
    send_cmd(OP_ABORT, 4'd0);
    chk("abort_pulse_low", pulse_out, 0);
    chk("abort_idle", pio_in[6], 0);
    chk("abort_done_held", pio_in[3:0], exp_done);
    repeat (3) @(posedge clk_clk);
    #1;
    chk("abort_stays_low", pulse_out, 0);
    mon_en = 1'b1;

    // done_cnt wrap over 16 bursts
    send_cmd(OP_WIDTH, 4'd0);
    send_cmd(OP_CLEAR, 4'd0);
    exp_done = 0;
    for (int b = 0; b < 16; b++) begin
      push_burst(0, 0);
      send_cmd(OP_FIRE, 4'd0);
      wait_idle(n);
      exp_done = (exp_done + 1) % 16;
      chk("wrap_done", pio_in[3:0], exp_done);
    end

    // Async reset mid-burst
    send_cmd(OP_WIDTH, 4'd2);
    send_cmd(OP_COUNT, 4'd3);
    mon_en = 1'b0;
    send_cmd(OP_FIRE, 4'd0);
    repeat (7) @(posedge clk_clk);
    #2;
    reset_reset_n = 1'b0;
    #1;
    chk("rst_mid_pulse_out", pulse_out, 0);
    chk("rst_mid_pio_in", pio_in, 8'h00);
    pio_out = 8'h00;
    tog     = 1'b0;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;
    chk("rst_rel_pio_in", pio_in, 8'h00);
    mon_en = 1'b1;
    push_burst(0, 0);
    send_cmd(OP_FIRE, 4'd0);
    chk("rst_fire_pulse", pulse_out, 1);
    wait_idle(n);
    chk("rst_fire_len", n, 8);
    chk("rst_fire_done", pio_in[3:0], 1);

    repeat (4) @(posedge clk_clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
